// File: rtl/cdb_writeback.sv
// cdb_writeback: result write-back stage of the Tomasulo core.
// Arbitrates completed FU results round-robin, broadcasts the winner on the
// common data bus one cycle later, and commits it to the register file and
// status table when the destination is still renamed to the producing unit.
module cdb_writeback #(
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX  = 3,
  parameter int NUM_FU    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic [NUM_FU*REG_INDEX-1:0]   fu_dest,
  input  logic [NUM_FU*WORD_SIZE-1:0]   fu_result,
  output logic [NUM_FU-1:0]             fu_ack,
  output logic                          cdb_valid,
  output logic [FU_INDEX-1:0]           cdb_tag,
  output logic [WORD_SIZE-1:0]          cdb_data,
  output logic [REG_INDEX-1:0]          lookup_num,
  input  logic [FU_INDEX-1:0]           lookup_status,
  input  logic                          issue_enable,
  input  logic [REG_INDEX-1:0]          issue_num,
  output logic [REG_INDEX-1:0]          write_reg_src,
  output logic [WORD_SIZE-1:0]          write_reg_data,
  output logic                          write_reg_enable,
  output logic [REG_INDEX-1:0]          write_rs_src,
  output logic [FU_INDEX-1:0]           write_rs_status,
  output logic                          write_rs_enable
);

  localparam int LG_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [FU_INDEX-1:0] READY = '0;

  // Per-FU views of the flattened slice buses
  logic [NUM_FU-1:0][REG_INDEX-1:0] dest_arr;
  logic [NUM_FU-1:0][WORD_SIZE-1:0] result_arr;
  assign dest_arr   = fu_dest;
  assign result_arr = fu_result;

  logic [LG_W-1:0]      last_grant;
  logic [LG_W-1:0]      win;
  logic                 any_grant;
  logic [REG_INDEX-1:0] cdb_dest;
  logic                 match;

  // Round-robin search starting one past the previous winner; first requester wins
  always_comb begin
    logic [LG_W-1:0] idx;
    fu_ack    = '0;
    win       = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = LG_W'((int'(last_grant) + 1 + k) % NUM_FU);
      if (!any_grant && fu_done[idx]) begin
        any_grant   = 1'b1;
        fu_ack[idx] = 1'b1;
        win         = idx;
      end
    end
  end

  // CDB stage: capture the winner's tag/dest/data; valid drops on idle cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= LG_W'(NUM_FU - 1);
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_dest   <= '0;
      cdb_data   <= '0;
    end else if (any_grant) begin
      last_grant <= win;
      cdb_valid  <= 1'b1;
      // FU i owns tag i+1, so READY (0) never appears on the bus
      cdb_tag    <= FU_INDEX'(win) + FU_INDEX'(1);
      cdb_dest   <= dest_arr[win];
      cdb_data   <= result_arr[win];
    end else begin
      cdb_valid  <= 1'b0;
    end
  end

  // Commit only if the register is still waiting on this producer. An issue
  // renaming the same register this cycle keeps its new status: write the
  // value but skip the clear.
  assign lookup_num       = cdb_dest;
  assign match            = cdb_valid && (lookup_status == cdb_tag);
  assign write_reg_enable = match;
  assign write_reg_src    = cdb_dest;
  assign write_reg_data   = cdb_data;
  assign write_rs_enable  = match && !(issue_enable && (issue_num == cdb_dest));
  assign write_rs_src     = cdb_dest;
  assign write_rs_status  = READY;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: reset, commit, round-robin, stale,
// issue collision, hold/idle and reset mid-handshake.
module tb_cdb_writeback;
  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        fu_done;
  logic [3:0][4:0]   fu_dest;
  logic [3:0][31:0]  fu_result;
  logic [3:0]        fu_ack;
  logic              cdb_valid;
  logic [2:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic [4:0]        lookup_num;
  logic [2:0]        lookup_status;
  logic              issue_enable;
  logic [4:0]        issue_num;
  logic [4:0]        write_reg_src;
  logic [31:0]       write_reg_data;
  logic              write_reg_enable;
  logic [4:0]        write_rs_src;
  logic [2:0]        write_rs_status;
  logic              write_rs_enable;

  int total = 0;
  int bad   = 0;

  cdb_writeback dut (
    .clk(clk), .reset(reset),
    .fu_done(fu_done), .fu_dest(fu_dest), .fu_result(fu_result), .fu_ack(fu_ack),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .lookup_num(lookup_num), .lookup_status(lookup_status),
    .issue_enable(issue_enable), .issue_num(issue_num),
    .write_reg_src(write_reg_src), .write_reg_data(write_reg_data),
    .write_reg_enable(write_reg_enable),
    .write_rs_src(write_rs_src), .write_rs_status(write_rs_status),
    .write_rs_enable(write_rs_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; fu_done = 4'b1111; fu_dest = '0; fu_result = '0;
    lookup_status = 3'd0; issue_enable = 1'b0; issue_num = '0;

    // Reset holds everything quiet even with all FUs requesting
    tick(); tick();
    chk("rst_valid", cdb_valid, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_lookup", lookup_num, 0);
    chk("rst_wre", write_reg_enable, 0);
    chk("rst_wrse", write_rs_enable, 0);
    reset = 1'b1;
    #1 chk("rst_first_ack", fu_ack, 4'b0001);
    tick();
    chk("rst_first_valid", cdb_valid, 1);
    chk("rst_first_tag", cdb_tag, 1);
    fu_done = 4'b0000;
    #1 chk("idle_ack", fu_ack, 4'b0000);
    tick();
    chk("idle_valid", cdb_valid, 0);

    // Single commit from FU2 (last grant = FU0)
    fu_dest[2] = 5'd7; fu_result[2] = 32'hDEADBEEF; fu_done = 4'b0100;
    lookup_status = 3'd3;
    #1 chk("c_ack", fu_ack, 4'b0100);
    tick();
    fu_done = 4'b0000;
    #1;
    chk("c_valid", cdb_valid, 1);
    chk("c_tag", cdb_tag, 3);
    chk("c_lookup", lookup_num, 7);
    chk("c_wre", write_reg_enable, 1);
    chk("c_wsrc", write_reg_src, 7);
    chk("c_wdata", write_reg_data, 32'hDEADBEEF);
    chk("c_wrse", write_rs_enable, 1);
    chk("c_rssrc", write_rs_src, 7);
    chk("c_rsstat", write_rs_status, 0);
    tick();

    // Round-robin: last grant FU2, so order is FU3,FU0,FU1,FU2,...
    for (int i = 0; i < 4; i++) begin
      fu_dest[i] = 5'(i + 1);
      fu_result[i] = 32'h1000_0000 + 32'(i);
    end
    fu_done = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = (3 + k) % 4;
      #1 chk("rr_ack", fu_ack, 4'b0001 << w);
      tick();
      chk("rr_tag", cdb_tag, 64'(w + 1));
      chk("rr_data", cdb_data, 32'h1000_0000 + 32'(w));
      chk("rr_valid", cdb_valid, 1);
    end
    fu_done = 4'b0000;
    tick();

    // Stale result: register now renamed to tag 2
    fu_dest[0] = 5'd5; fu_done = 4'b0001; lookup_status = 3'd2;
    #1 chk("s_ack", fu_ack, 4'b0001);
    tick();
    fu_done = 4'b0000;
    #1;
    chk("s_valid", cdb_valid, 1);
    chk("s_tag", cdb_tag, 1);
    chk("s_lookup", lookup_num, 5);
    chk("s_wre", write_reg_enable, 0);
    chk("s_wrse", write_rs_enable, 0);
    tick();

    // Issue collision on the committed register
    fu_dest[1] = 5'd9; fu_done = 4'b0010;
    tick();
    fu_done = 4'b0000; lookup_status = 3'd2; issue_enable = 1'b1; issue_num = 5'd9;
    #1;
    chk("i_tag", cdb_tag, 2);
    chk("i_wre", write_reg_enable, 1);
    chk("i_wrse", write_rs_enable, 0);
    issue_num = 5'd10;
    #1;
    chk("i2_wre", write_reg_enable, 1);
    chk("i2_wrse", write_rs_enable, 1);
    issue_enable = 1'b0;
    tick();

    // Hold and idle: FU3 alone, then nothing
    fu_result[3] = 32'hCAFEF00D; fu_done = 4'b1000; lookup_status = 3'd4;
    #1 chk("h_ack", fu_ack, 4'b1000);
    tick();
    fu_done = 4'b0000;
    #1;
    chk("h_valid", cdb_valid, 1);
    chk("h_data", cdb_data, 32'hCAFEF00D);
    chk("h_wre", write_reg_enable, 1);
    tick();
    chk("h_idle_valid", cdb_valid, 0);
    chk("h_idle_data", cdb_data, 32'hCAFEF00D);
    chk("h_idle_wre", write_reg_enable, 0);
    chk("h_idle_wrse", write_rs_enable, 0);

    // Reset mid-handshake: capture lost, FU re-granted afterwards
    fu_dest[1] = 5'd3; fu_done = 4'b0010;
    #1 chk("m_ack", fu_ack, 4'b0010);
    reset = 1'b0;
    #1;
    chk("m_rst_valid", cdb_valid, 0);
    chk("m_rst_ack", fu_ack, 4'b0010);
    tick();
    chk("m_rst_hold", cdb_valid, 0);
    reset = 1'b1;
    tick();
    chk("m_regrant_valid", cdb_valid, 1);
    chk("m_regrant_tag", cdb_tag, 2);
    chk("m_regrant_lookup", lookup_num, 3);
    fu_done = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
